vadd_axi_slave_mem: RTL and testbench

- AXI4 slave memory model that responds to the reduced AXI4 master port of the vadd kernels: AW/W/B and AR/R, with no ID, size, burst or resp signals.
- Backs both directions with one word-addressed register array, so a kernel's read master and write master can run against it in block-level testbenches and loopback builds.
- Read and write channels are serviced by independent state machines, with one outstanding burst per direction.

---
 rtl/vadd_axi_slave_mem.sv | 206 ++++++++++++++++++++
 tb/tb_vadd_axi_slave_mem.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vadd_axi_slave_mem.sv
// Purpose : AXI4 slave memory model for the reduced vadd master port (AW/W/B, AR/R).
// Latency : AR handshake -> first rvalid 1 cycle; then 1 beat/cycle. Last W beat -> bvalid next cycle.
// Backpres: all ready/valid outputs are registered from FSM state; R beats hold while rready=0.
//
// Ports:
//   aclk, areset        - clock and synchronous active-high reset
//   s_axi_aw*/w*/b*     - write address, data and response channels
//   s_axi_ar*/r*        - read address and data channels
//   wlast_err           - sticky flag: wlast disagreed with the awlen beat count
// Optional build macro VADD_SLV_BACKPRESSURE_EN adds LFSR-driven pseudo-random stalls.
module vadd_axi_slave_mem #(
  parameter int          C_M_AXI_ADDR_WIDTH = 64,
  parameter int          C_M_AXI_DATA_WIDTH = 512,
  parameter int          C_MEM_DEPTH        = 1024,
  parameter logic [15:0] C_BP_SEED          = 16'hACE1
) (
  input  logic                            aclk,
  input  logic                            areset,
  input  logic                            s_axi_awvalid,
  output logic                            s_axi_awready,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic [7:0]                      s_axi_awlen,
  input  logic                            s_axi_wvalid,
  output logic                            s_axi_wready,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [C_M_AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                            s_axi_wlast,
  output logic                            s_axi_bvalid,
  input  logic                            s_axi_bready,
  input  logic                            s_axi_arvalid,
  output logic                            s_axi_arready,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic [7:0]                      s_axi_arlen,
  output logic                            s_axi_rvalid,
  input  logic                            s_axi_rready,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   s_axi_rdata,
  output logic                            s_axi_rlast,
  output logic                            wlast_err
);

  localparam int NBYTES   = C_M_AXI_DATA_WIDTH / 8;
  localparam int ADDR_LSB = $clog2(NBYTES);
  localparam int IDX_W    = $clog2(C_MEM_DEPTH);

  typedef logic [IDX_W-1:0] idx_t;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

  logic [C_M_AXI_DATA_WIDTH-1:0] mem [C_MEM_DEPTH];

  // bp_rdy gates the ready outputs; bp_go permits starting an R beat or raising bvalid.
  logic bp_rdy;
  logic bp_go;

`ifdef VADD_SLV_BACKPRESSURE_EN
  logic [15:0] lfsr;

  // Right-shifting Galois LFSR, taps 16,14,13,11.
  always_ff @(posedge aclk) begin
    if (areset) lfsr <= C_BP_SEED;
    else        lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
  end

  assign bp_rdy = lfsr[0];
  assign bp_go  = lfsr[1];
`else
  assign bp_rdy = 1'b1;
  assign bp_go  = 1'b1;
`endif

  // Address bits above the memory index and below the word offset are ignored.
  logic unused_ok;
  assign unused_ok = &{1'b0, s_axi_awaddr, s_axi_araddr, C_BP_SEED};

  // ---------------- write channel ----------------
  w_state_t   w_state;
  idx_t       w_idx;
  logic [8:0] w_cnt;
  logic       awready_q;
  logic       wready_q;
  logic       aw_fire;
  logic       w_fire;

  assign s_axi_awready = awready_q & bp_rdy;
  assign s_axi_wready  = wready_q & bp_rdy;
  assign aw_fire       = s_axi_awvalid & s_axi_awready;
  assign w_fire        = s_axi_wvalid & s_axi_wready;

  always_ff @(posedge aclk) begin
    if (areset) begin
      w_state      <= W_IDLE;
      awready_q    <= 1'b1;
      wready_q     <= 1'b0;
      s_axi_bvalid <= 1'b0;
      wlast_err    <= 1'b0;
      w_idx        <= '0;
      w_cnt        <= '0;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (aw_fire) begin
            w_idx     <= s_axi_awaddr[ADDR_LSB +: IDX_W];
            w_cnt     <= {1'b0, s_axi_awlen} + 9'd1;
            awready_q <= 1'b0;
            wready_q  <= 1'b1;
            w_state   <= W_DATA;
          end
        end
        W_DATA: begin
          if (w_fire) begin
            w_idx <= w_idx + idx_t'(1);
            w_cnt <= w_cnt - 9'd1;
            // Flag only; the awlen count alone decides when the burst ends.
            if (s_axi_wlast != (w_cnt == 9'd1)) wlast_err <= 1'b1;
            if (w_cnt == 9'd1) begin
              wready_q     <= 1'b0;
              s_axi_bvalid <= bp_go;
              w_state      <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (!s_axi_bvalid) begin
            s_axi_bvalid <= bp_go;
          end else if (s_axi_bready) begin
            s_axi_bvalid <= 1'b0;
            awready_q    <= 1'b1;
            w_state      <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // Memory is intentionally not reset; a beat landing in a reset cycle is dropped.
  always_ff @(posedge aclk) begin
    if (!areset && w_fire) begin
      for (int b = 0; b < NBYTES; b++) begin
        if (s_axi_wstrb[b]) mem[w_idx][b*8 +: 8] <= s_axi_wdata[b*8 +: 8];
      end
    end
  end

  // ---------------- read channel ----------------
  r_state_t   r_state;
  idx_t       r_idx;   // index of the next beat to load
  logic [8:0] r_rem;   // beats not yet loaded into rdata
  logic       arready_q;
  logic       ar_fire;
  idx_t       ar_idx;

  assign s_axi_arready = arready_q & bp_rdy;
  assign ar_fire       = s_axi_arvalid & s_axi_arready;
  assign ar_idx        = s_axi_araddr[ADDR_LSB +: IDX_W];

  // rdata loads with the pre-write memory value when a W beat hits the same word.
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_state      <= R_IDLE;
      arready_q    <= 1'b1;
      s_axi_rvalid <= 1'b0;
      s_axi_rlast  <= 1'b0;
      s_axi_rdata  <= '0;
      r_idx        <= '0;
      r_rem        <= '0;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (ar_fire) begin
            arready_q <= 1'b0;
            r_state   <= R_DATA;
            if (bp_go) begin
              s_axi_rdata  <= mem[ar_idx];
              s_axi_rvalid <= 1'b1;
              s_axi_rlast  <= (s_axi_arlen == 8'd0);
              r_idx        <= ar_idx + idx_t'(1);
              r_rem        <= {1'b0, s_axi_arlen};
            end else begin
              r_idx <= ar_idx;
              r_rem <= {1'b0, s_axi_arlen} + 9'd1;
            end
          end
        end
        R_DATA: begin
          if (s_axi_rvalid && s_axi_rready && s_axi_rlast) begin
            s_axi_rvalid <= 1'b0;
            s_axi_rlast  <= 1'b0;
            arready_q    <= 1'b1;
            r_state      <= R_IDLE;
          end else if ((!s_axi_rvalid || s_axi_rready) && bp_go) begin
            s_axi_rdata  <= mem[r_idx];
            s_axi_rvalid <= 1'b1;
            s_axi_rlast  <= (r_rem == 9'd1);
            r_idx        <= r_idx + idx_t'(1);
            r_rem        <= r_rem - 9'd1;
          end else if (s_axi_rready) begin
            s_axi_rvalid <= 1'b0;
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vadd_axi_slave_mem.sv
// Purpose : directed self-checking bench for vadd_axi_slave_mem (16-word memory, 512-bit data).
// Latency : inputs driven and outputs sampled 1 time unit after each rising edge.
// Backpres: read driver can hold rready low in a 1,0,0 pattern to exercise stalls.
module tb_vadd_axi_slave_mem;

  localparam int AW    = 64;
  localparam int DW    = 512;
  localparam int SB    = DW / 8;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          areset;
  logic          s_axi_awvalid, s_axi_awready;
  logic [AW-1:0] s_axi_awaddr;
  logic [7:0]    s_axi_awlen;
  logic          s_axi_wvalid, s_axi_wready;
  logic [DW-1:0] s_axi_wdata;
  logic [SB-1:0] s_axi_wstrb;
  logic          s_axi_wlast;
  logic          s_axi_bvalid, s_axi_bready;
  logic          s_axi_arvalid, s_axi_arready;
  logic [AW-1:0] s_axi_araddr;
  logic [7:0]    s_axi_arlen;
  logic          s_axi_rvalid, s_axi_rready;
  logic [DW-1:0] s_axi_rdata;
  logic          s_axi_rlast;
  logic          wlast_err;

  always #5 clk = ~clk;

  vadd_axi_slave_mem #(
    .C_M_AXI_ADDR_WIDTH(AW),
    .C_M_AXI_DATA_WIDTH(DW),
    .C_MEM_DEPTH(DEPTH),
    .C_BP_SEED(16'hACE1)
  ) dut (
    .aclk(clk), .areset(areset),
    .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
    .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
    .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .s_axi_rdata(s_axi_rdata), .s_axi_rlast(s_axi_rlast),
    .wlast_err(wlast_err)
  );

  int checks = 0;
  int passed = 0;

  logic [DW-1:0] wbeat   [256];
  logic [DW-1:0] mem_ref [DEPTH];

  // Observations from the write driver
  int w_beats, w_bcnt;
  bit w_early_b, w_timeout;
  // Observations from the read driver
  logic [DW-1:0] rd      [256];
  bit            rd_last [256];
  int r_beats, r_cycles;
  bit r_lat1, r_stable_err, r_timeout;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    areset = 1'b1;
    step();
    step();
    areset = 1'b0;
  endtask

  // Drives one write burst from wbeat[]; bad_last<0 means correct wlast, else wlast on that beat only.
  task automatic do_write(input logic [AW-1:0] addr, input logic [7:0] len,
                          input logic [SB-1:0] strb, input int bad_last);
    int n;
    int beat;
    int cyc;
    int idx;
    bit fire;
    n = int'(len) + 1;
    beat = 0;
    cyc = 0;
    w_bcnt = 0;
    w_early_b = 0;
    w_timeout = 0;
    s_axi_awaddr  = addr;
    s_axi_awlen   = len;
    s_axi_awvalid = 1'b1;
    do begin
      fire = s_axi_awready;
      step();
      cyc++;
    end while (!fire && cyc < 50);
    s_axi_awvalid = 1'b0;
    if (!fire) w_timeout = 1;
    cyc = 0;
    while (beat < n && cyc < 1000 && !w_timeout) begin
      s_axi_wvalid = 1'b1;
      s_axi_wdata  = wbeat[beat];
      s_axi_wstrb  = strb;
      s_axi_wlast  = (bad_last < 0) ? (beat == n - 1) : (beat == bad_last);
      if (s_axi_bvalid) w_early_b = 1;
      fire = s_axi_wready;
      step();
      cyc++;
      if (fire) begin
        idx = (int'(addr >> 6) + beat) % DEPTH;
        for (int b = 0; b < SB; b++)
          if (strb[b]) mem_ref[idx][b*8 +: 8] = wbeat[beat][b*8 +: 8];
        beat++;
      end
    end
    if (beat < n) w_timeout = 1;
    s_axi_wvalid = 1'b0;
    s_axi_wlast  = 1'b0;
    w_beats = beat;
    for (int i = 0; i < 6; i++) begin
      if (s_axi_bvalid) w_bcnt++;
      step();
    end
  endtask

  // mode 0: rready always high; mode 1: rready pattern 1,0,0,1,0,0...
  task automatic do_read(input logic [AW-1:0] addr, input logic [7:0] len, input int mode);
    int n;
    int beat;
    int cyc;
    bit fire;
    bit held;
    logic [DW-1:0] prev_d;
    logic          prev_l;
    n = int'(len) + 1;
    beat = 0;
    cyc = 0;
    held = 0;
    prev_d = '0;
    prev_l = 1'b0;
    r_timeout = 0;
    r_stable_err = 0;
    s_axi_araddr  = addr;
    s_axi_arlen   = len;
    s_axi_arvalid = 1'b1;
    s_axi_rready  = 1'b0;
    do begin
      fire = s_axi_arready;
      step();
      cyc++;
    end while (!fire && cyc < 50);
    s_axi_arvalid = 1'b0;
    if (!fire) r_timeout = 1;
    r_lat1 = s_axi_rvalid;
    cyc = 0;
    while (beat < n && cyc < 2000 && !r_timeout) begin
      s_axi_rready = (mode == 0) || (cyc % 3 == 0);
      if (held && (!s_axi_rvalid || s_axi_rdata !== prev_d || s_axi_rlast !== prev_l))
        r_stable_err = 1;
      fire = s_axi_rvalid && s_axi_rready;
      if (fire) begin
        rd[beat]      = s_axi_rdata;
        rd_last[beat] = s_axi_rlast;
      end
      held   = s_axi_rvalid && !s_axi_rready;
      prev_d = s_axi_rdata;
      prev_l = s_axi_rlast;
      step();
      cyc++;
      if (fire) beat++;
    end
    s_axi_rready = 1'b0;
    r_cycles = cyc;
    r_beats  = beat;
    if (beat < n) r_timeout = 1;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (s_axi_awready !== 1'b1) $display("FAIL reset_awready: got %b want 1", s_axi_awready); else passed++;
    checks++; if (s_axi_arready !== 1'b1) $display("FAIL reset_arready: got %b want 1", s_axi_arready); else passed++;
    checks++; if (s_axi_wready !== 1'b0) $display("FAIL reset_wready: got %b want 0", s_axi_wready); else passed++;
    checks++; if (s_axi_bvalid !== 1'b0) $display("FAIL reset_bvalid: got %b want 0", s_axi_bvalid); else passed++;
    checks++; if (s_axi_rvalid !== 1'b0) $display("FAIL reset_rvalid: got %b want 0", s_axi_rvalid); else passed++;
    checks++; if (s_axi_rlast !== 1'b0) $display("FAIL reset_rlast: got %b want 0", s_axi_rlast); else passed++;
    checks++; if (s_axi_rdata !== '0) $display("FAIL reset_rdata: got %h want 0", s_axi_rdata); else passed++;
    checks++; if (wlast_err !== 1'b0) $display("FAIL reset_wlast_err: got %b want 0", wlast_err); else passed++;
  endtask

  task automatic test_write_burst();
    for (int i = 0; i < 4; i++) wbeat[i] = DW'(i);
    do_write(64'h0, 8'd3, '1, -1);
    checks++; if (w_timeout) $display("FAIL wr_timeout: got 1 want 0"); else passed++;
    checks++; if (w_beats != 4) $display("FAIL wr_beats: got %0d want 4", w_beats); else passed++;
    checks++; if (w_bcnt != 1) $display("FAIL wr_bvalid_cycles: got %0d want 1", w_bcnt); else passed++;
    checks++; if (w_early_b) $display("FAIL wr_early_b: got 1 want 0"); else passed++;
    checks++; if (wlast_err !== 1'b0) $display("FAIL wr_wlast_err: got %b want 0", wlast_err); else passed++;
    checks++; if (s_axi_awready !== 1'b1) $display("FAIL wr_awready_back: got %b want 1", s_axi_awready); else passed++;
  endtask

  task automatic test_read_back();
    do_read(64'h0, 8'd3, 0);
    checks++; if (r_timeout) $display("FAIL rd_timeout: got 1 want 0"); else passed++;
    checks++; if (!r_lat1) $display("FAIL rd_latency: rvalid got 0 want 1 one cycle after AR"); else passed++;
    checks++; if (r_cycles != 4) $display("FAIL rd_throughput: got %0d cycles want 4", r_cycles); else passed++;
    for (int i = 0; i < 4; i++) begin
      checks++; if (rd[i] !== DW'(i)) $display("FAIL rd_data[%0d]: got %h want %0d", i, rd[i], i); else passed++;
      checks++; if (rd_last[i] !== (i == 3)) $display("FAIL rd_last[%0d]: got %b want %b", i, rd_last[i], i == 3); else passed++;
    end
    checks++; if (s_axi_arready !== 1'b1) $display("FAIL rd_arready_back: got %b want 1", s_axi_arready); else passed++;
    checks++; if (s_axi_rvalid !== 1'b0) $display("FAIL rd_rvalid_drop: got %b want 0", s_axi_rvalid); else passed++;
  endtask

  task automatic test_partial_strobe();
    logic [DW-1:0] expv;
    expv = {{15{32'h12345678}}, 32'hFFFF_FFFF};
    wbeat[0] = {16{32'h12345678}};
    do_write(64'd5 * 64, 8'd0, '1, -1);
    wbeat[0] = '1;
    do_write(64'd5 * 64, 8'd0, 64'h000F, -1);
    do_read(64'd5 * 64, 8'd0, 0);
    checks++; if (rd[0] !== expv) $display("FAIL strobe_data: got %h want %h", rd[0], expv); else passed++;
    checks++; if (rd_last[0] !== 1'b1) $display("FAIL strobe_rlast: got %b want 1", rd_last[0]); else passed++;
  endtask

  task automatic test_wrap_backpressure();
    logic [DW-1:0] expv;
    for (int i = 0; i < 4; i++) wbeat[i] = {16{32'hCAFE_0000 + 32'(i)}};
    do_write(64'd14 * 64, 8'd3, '1, -1);
    do_read(64'd14 * 64, 8'd3, 1);
    checks++; if (r_timeout) $display("FAIL wrap_timeout: got 1 want 0"); else passed++;
    checks++; if (r_stable_err) $display("FAIL wrap_hold_stable: output changed while rready=0"); else passed++;
    for (int i = 0; i < 4; i++) begin
      expv = {16{32'hCAFE_0000 + 32'(i)}};
      checks++; if (rd[i] !== expv) $display("FAIL wrap_data[%0d]: got %h want %h", i, rd[i], expv); else passed++;
    end
    checks++; if (rd_last[3] !== 1'b1 || rd_last[2] !== 1'b0) $display("FAIL wrap_rlast: got %b%b want 10", rd_last[3], rd_last[2]); else passed++;
    // Word 0 was written by beat 2; address 17*64+5 aliases word 1 (beat 3).
    do_read(64'h0, 8'd0, 0);
    expv = {16{32'hCAFE_0002}};
    checks++; if (rd[0] !== expv) $display("FAIL wrap_word0: got %h want %h", rd[0], expv); else passed++;
    do_read(64'd17 * 64 + 64'd5, 8'd0, 0);
    expv = {16{32'hCAFE_0003}};
    checks++; if (rd[0] !== expv) $display("FAIL wrap_alias_word1: got %h want %h", rd[0], expv); else passed++;
  endtask

  task automatic test_protocol_error();
    wbeat[0] = {16{32'h0BAD_0000}};
    wbeat[1] = {16{32'h0BAD_0001}};
    do_write(64'd9 * 64, 8'd1, '1, 0);
    checks++; if (w_beats != 2) $display("FAIL perr_beats: got %0d want 2", w_beats); else passed++;
    checks++; if (w_bcnt != 1) $display("FAIL perr_bvalid_cycles: got %0d want 1", w_bcnt); else passed++;
    checks++; if (w_early_b) $display("FAIL perr_early_b: got 1 want 0"); else passed++;
    checks++; if (wlast_err !== 1'b1) $display("FAIL perr_flag: got %b want 1", wlast_err); else passed++;
    for (int i = 0; i < 3; i++) step();
    checks++; if (wlast_err !== 1'b1) $display("FAIL perr_sticky: got %b want 1", wlast_err); else passed++;
    apply_reset();
    checks++; if (wlast_err !== 1'b0) $display("FAIL perr_reset_clear: got %b want 0", wlast_err); else passed++;
  endtask

  task automatic test_concurrent_long();
    for (int i = 0; i < 256; i++) wbeat[i] = {16{32'(i * 3 + 7)}};
    fork
      do_write(64'h0, 8'd255, '1, -1);
      do_read(64'd12 * 64, 8'd3, 0);
    join
    checks++; if (w_beats != 256) $display("FAIL long_beats: got %0d want 256", w_beats); else passed++;
    checks++; if (w_bcnt != 1) $display("FAIL long_bvalid_cycles: got %0d want 1", w_bcnt); else passed++;
    checks++; if (wlast_err !== 1'b0) $display("FAIL long_wlast_err: got %b want 0", wlast_err); else passed++;
    checks++; if (r_beats != 4 || r_timeout) $display("FAIL conc_read_beats: got %0d want 4", r_beats); else passed++;
    checks++; if (rd_last[3] !== 1'b1) $display("FAIL conc_read_rlast: got %b want 1", rd_last[3]); else passed++;
    do_read(64'h0, 8'd15, 0);
    for (int i = 0; i < DEPTH; i++) begin
      checks++; if (rd[i] !== mem_ref[i]) $display("FAIL long_image[%0d]: got %h want %h", i, rd[i], mem_ref[i]); else passed++;
    end
    // Word k ends holding beat 240+k.
    checks++; if (rd[15] !== {16{32'(255 * 3 + 7)}}) $display("FAIL long_last_word: got %h want %h", rd[15], {16{32'(255 * 3 + 7)}}); else passed++;
  endtask

  initial begin
    areset        = 1'b1;
    s_axi_awvalid = 1'b0;
    s_axi_awaddr  = '0;
    s_axi_awlen   = '0;
    s_axi_wvalid  = 1'b0;
    s_axi_wdata   = '0;
    s_axi_wstrb   = '0;
    s_axi_wlast   = 1'b0;
    s_axi_bready  = 1'b1;
    s_axi_arvalid = 1'b0;
    s_axi_araddr  = '0;
    s_axi_arlen   = '0;
    s_axi_rready  = 1'b0;
    test_reset();
    test_write_burst();
    test_read_back();
    test_partial_strobe();
    test_wrap_backpressure();
    test_protocol_error();
    test_concurrent_long();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d so far", passed, checks);
    $fatal(1, "watchdog expired");
  end

endmodule
